// File: rtl/deser_pkg.sv
// -----------------------------------------------------------------------------
// deser_pkg
// Shared definitions for the bit deserializer:
//   DEFAULT_WIDTH : default number of bits per assembled word
//   state_e       : controller states (IDLE, SHIFT, DONE)
// -----------------------------------------------------------------------------
package deser_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage : deser_pkg

// File: rtl/bit_demux.sv
// -----------------------------------------------------------------------------
// bit_demux
// Combinational 1:N write decoder. It turns a bit index plus a write enable
// into a one-hot mask that selects the single shadow bit to be written.
// Ports:
//   idx_i  : bit position to write (IDX_W bits)
//   we_i   : write enable; when low the mask is all zeros
//   mask_o : one-hot write mask (WIDTH bits)
// -----------------------------------------------------------------------------
module bit_demux
    import deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [IDX_W-1:0] idx_i,
    input  logic             we_i,
    output logic [WIDTH-1:0] mask_o
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dec
            assign mask_o[gi] = we_i && (idx_i == IDX_W'(gi));
        end
    endgenerate

endmodule : bit_demux

// File: rtl/bit_deserializer.sv
// -----------------------------------------------------------------------------
// bit_deserializer
// Assembles WIDTH serial bits (LSB first) into a parallel word.
// Ports:
//   Clock    : single clock, all state updates on the rising edge
//   Reset    : synchronous active-high reset, highest priority
//   Start    : begin a new word (honoured in IDLE and DONE)
//   Abort    : drop the word in progress and go to IDLE (beats Start)
//   SerialIn : serial data bit
//   InValid  : SerialIn is valid this cycle (used only in SHIFT)
//   ParOut   : last completed word, updated only on the completion edge
//   OutValid : one-cycle pulse while in DONE
//   Busy     : high while in SHIFT
//   BitIndex : position the next valid bit will be written to
// -----------------------------------------------------------------------------
module bit_deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Abort,
    input  logic             SerialIn,
    input  logic             InValid,
    output logic [WIDTH-1:0] ParOut,
    output logic             OutValid,
    output logic             Busy,
    output logic [IDX_W-1:0] BitIndex
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   shadow_q, shadow_d;
    logic [WIDTH-1:0]   par_q, par_d;

    logic               bit_we;
    logic [WIDTH-1:0]   bit_mask;
    logic [WIDTH-1:0]   shadow_wr;
    logic               last_bit;

    // A bit is written only in SHIFT, and an abort suppresses the write.
    assign bit_we = (state_q == SHIFT) && InValid && !Abort;

    bit_demux #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_bit_demux (
        .idx_i  (idx_q),
        .we_i   (bit_we),
        .mask_o (bit_mask)
    );

    // Shadow word with the current bit merged in; also the value published
    // on completion so the final bit lands in ParOut on the same edge.
    assign shadow_wr = (shadow_q & ~bit_mask) | (bit_mask & {WIDTH{SerialIn}});
    assign last_bit  = (idx_q == IDX_W'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        par_d    = par_q;

        case (state_q)
            IDLE, DONE: begin
                // DONE lasts exactly one cycle; Start here chains the next word.
                state_d = IDLE;
                if (!Abort && Start) begin
                    state_d  = SHIFT;
                    idx_d    = '0;
                    shadow_d = '0;
                end
            end

            SHIFT: begin
                if (Abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (InValid) begin
                    shadow_d = shadow_wr;
                    if (last_bit) begin
                        state_d = DONE;
                        idx_d   = '0;
                        par_d   = shadow_wr;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            shadow_q <= '0;
            par_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            par_q    <= par_d;
        end
    end

    assign ParOut   = par_q;
    assign OutValid = (state_q == DONE);
    assign Busy     = (state_q == SHIFT);
    assign BitIndex = idx_q;

endmodule : bit_deserializer

// File: tb/tb_bit_deserializer.sv
module tb_bit_deserializer;

    localparam int W  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          Reset, Start, Abort, SerialIn, InValid;
    logic [W-1:0]  ParOut;
    logic          OutValid, Busy;
    logic [IW-1:0] BitIndex;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ov_cnt   = 0;
    int last_ov  = -1;

    // Reference model: a capture flag plus a queue of received bits.
    bit           m_cap  = 1'b0;
    bit           m_q[$];
    logic [W-1:0] m_word = '0;
    bit           m_done = 1'b0;

    always #5 clk = ~clk;

    bit_deserializer #(.WIDTH(W), .IDX_W(IW)) dut (
        .Clock    (clk),
        .Reset    (Reset),
        .Start    (Start),
        .Abort    (Abort),
        .SerialIn (SerialIn),
        .InValid  (InValid),
        .ParOut   (ParOut),
        .OutValid (OutValid),
        .Busy     (Busy),
        .BitIndex (BitIndex)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit a, input bit d, input bit v);
        bit done_n;
        done_n = 1'b0;
        if (r) begin
            m_cap = 1'b0;
            m_q.delete();
            m_word = '0;
        end else if (m_cap) begin
            if (a) begin
                m_cap = 1'b0;
                m_q.delete();
            end else if (v) begin
                m_q.push_back(d);
                if (m_q.size() == W) begin
                    for (int i = 0; i < W; i++) m_word[i] = m_q[i];
                    m_q.delete();
                    m_cap  = 1'b0;
                    done_n = 1'b1;
                end
            end
        end else if (!a && s) begin
            m_cap = 1'b1;
            m_q.delete();
        end
        m_done = done_n;
    endtask

    // One clock: drive inputs, advance the model, sample #1 after the edge.
    task automatic cycle(input bit r, input bit s, input bit a, input bit d, input bit v);
        Reset = r; Start = s; Abort = a; SerialIn = d; InValid = v;
        @(posedge clk);
        model_step(r, s, a, d, v);
        #1;
        cyc++;
        if (OutValid === 1'b1) begin
            ov_cnt++;
            last_ov = cyc;
        end
        chk("model_par",  32'(ParOut),   32'(m_word));
        chk("model_ov",   32'(OutValid), 32'(m_done));
        chk("model_busy", 32'(Busy),     32'(m_cap));
        chk("model_idx",  32'(BitIndex), m_cap ? 32'(m_q.size()) : 32'd0);
    endtask

    typedef struct {
        bit           s, a, d, v;
        logic [W-1:0] par;
        bit           ov, busy;
        int           idx;
    } vec_t;

    function automatic vec_t mk(bit s, bit a, bit d, bit v, logic [W-1:0] par,
                                bit ov, bit busy, int idx);
        vec_t t;
        t.s = s; t.a = a; t.d = d; t.v = v;
        t.par = par; t.ov = ov; t.busy = busy; t.idx = idx;
        return t;
    endfunction

    initial begin
        vec_t tbl[$];
        bit   b4d[8];
        bit   ba5[8];
        int   c0, n0;

        b4d = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        ba5 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        // Word 8'h4D, then a word whose 8th bit collides with Abort.
        tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 1, 0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 0, b4d[i], 1, (i == 7) ? 8'h4D : 8'h00,
                             i == 7, i != 7, (i + 1) % 8));
        tbl.push_back(mk(0, 0, 0, 0, 8'h4D, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 8'h4D, 0, 1, 0));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(0, 0, 1, 1, 8'h4D, 0, 1, i + 1));
        tbl.push_back(mk(0, 1, 1, 1, 8'h4D, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 8'h4D, 0, 0, 0));
        // Abort+Start together in IDLE: stays IDLE.
        tbl.push_back(mk(1, 1, 0, 0, 8'h4D, 0, 0, 0));

        // Reset with all other inputs active.
        cycle(1, 1, 0, 1, 1);
        cycle(1, 0, 1, 1, 1);
        chk("rst_par",  32'(ParOut),   32'h0);
        chk("rst_ov",   32'(OutValid), 32'h0);
        chk("rst_busy", 32'(Busy),     32'h0);
        chk("rst_idx",  32'(BitIndex), 32'h0);

        // Table-driven vectors.
        n0 = ov_cnt;
        c0 = cyc;
        foreach (tbl[i]) begin
            cycle(0, tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].v);
            chk($sformatf("tbl%0d_par", i),  32'(ParOut),   32'(tbl[i].par));
            chk($sformatf("tbl%0d_ov", i),   32'(OutValid), 32'(tbl[i].ov));
            chk($sformatf("tbl%0d_busy", i), 32'(Busy),     32'(tbl[i].busy));
            chk($sformatf("tbl%0d_idx", i),  32'(BitIndex), 32'(tbl[i].idx));
        end
        chk("tbl_ov_count", 32'(ov_cnt - n0), 32'd1);
        chk("tbl_latency",  32'(last_ov - (c0 + 1)), 32'd8);

        // Stall of 3 cycles after bit 4: OutValid 3 cycles later.
        n0 = ov_cnt;
        cycle(0, 1, 0, 0, 0);
        c0 = cyc;
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, b4d[i], 1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 1, 0);
            chk("stall_idx", 32'(BitIndex), 32'd4);
        end
        for (int i = 4; i < 8; i++) cycle(0, 0, 0, b4d[i], 1);
        cycle(0, 0, 0, 0, 0);
        chk("stall_latency", 32'(last_ov - c0), 32'd11);
        chk("stall_ov_count", 32'(ov_cnt - n0), 32'd1);
        chk("stall_par", 32'(ParOut), 32'h4D);

        // Back-to-back words: Start in DONE, InValid there is ignored.
        n0 = ov_cnt;
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, b4d[i], 1);
        chk("b2b_first_ov", 32'(OutValid), 32'd1);
        cycle(0, 1, 0, 0, 1);
        chk("b2b_busy", 32'(Busy), 32'd1);
        chk("b2b_idx",  32'(BitIndex), 32'd0);
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 0, 1, 1);
            if (i < 7) chk("b2b_hold_par", 32'(ParOut), 32'h4D);
        end
        chk("b2b_second_ov",  32'(OutValid), 32'd1);
        chk("b2b_second_par", 32'(ParOut),   32'hFF);
        chk("b2b_ov_count",   32'(ov_cnt - n0), 32'd2);

        // Reset after 5 bits, then a full 8'hA5.
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 1);
        n0 = ov_cnt;
        cycle(1, 1, 1, 1, 1);
        chk("midrst_busy", 32'(Busy), 32'd0);
        chk("midrst_par",  32'(ParOut), 32'h0);
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, ba5[i], 1);
        cycle(0, 0, 0, 0, 0);
        chk("midrst_ov_count", 32'(ov_cnt - n0), 32'd1);
        chk("midrst_par_a5",   32'(ParOut), 32'hA5);

        // InValid in IDLE and Start in SHIFT have no effect.
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 1, 1);
            chk("idle_inval_idx", 32'(BitIndex), 32'd0);
        end
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, b4d[i], 1);
        cycle(0, 1, 0, 1, 0);
        chk("shift_start_idx", 32'(BitIndex), 32'd3);
        chk("shift_start_par", 32'(ParOut),   32'hA5);
        for (int i = 3; i < 8; i++) cycle(0, 0, 0, b4d[i], 1);
        chk("shift_start_final", 32'(ParOut), 32'h4D);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 99) < 1,
                  $urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < 3,
                  1'($urandom),
                  $urandom_range(0, 99) < 70);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bit_deserializer
